// File: rtl/ttl_gate_bank_sync.sv
// Bank of CHANNELS clocked gates (NOR/OR/NAND/AND), each delayed through a
// LATENCY-stage pipeline and passed through a per-channel FILTER-cycle glitch filter.
module ttl_gate_bank_sync #(
  parameter int unsigned         CHANNELS  = 3,
  parameter int unsigned         INPUTS    = 3,
  parameter int unsigned         LATENCY   = 2,
  parameter int unsigned         FILTER    = 3,
  parameter logic [CHANNELS-1:0] RESET_VAL = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          tgl
);

  localparam int unsigned       CNT_W   = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER - 1);

  logic [CHANNELS-1:0] g_c;
  logic [CHANNELS-1:0] d_c;

  // Combinational gate function per channel slice
  always_comb begin
    g_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      case (mode)
        2'b00:   g_c[c] = ~(|a[c*INPUTS +: INPUTS]);
        2'b01:   g_c[c] =  (|a[c*INPUTS +: INPUTS]);
        2'b10:   g_c[c] = ~(&a[c*INPUTS +: INPUTS]);
        default: g_c[c] =  (&a[c*INPUTS +: INPUTS]);
      endcase
    end
  end

  // Propagation-delay pipeline; the y register supplies the final stage
  if (LATENCY > 1) begin : g_pipe
    localparam int unsigned NSTG = LATENCY - 1;

    logic [CHANNELS-1:0] stg_q [NSTG];
    logic [CHANNELS-1:0] stg_d [NSTG];

    always_comb begin
      stg_d = stg_q;
      if (en) begin
        stg_d[0] = g_c;
        for (int i = 1; i < int'(NSTG); i++) begin
          stg_d[i] = stg_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(NSTG); i++) begin
          stg_q[i] <= RESET_VAL;
        end
      end else begin
        stg_q <= stg_d;
      end
    end

    assign d_c = stg_q[NSTG-1];
  end else begin : g_nopipe
    assign d_c = g_c;
  end

  logic [CHANNELS-1:0] y_q,   y_d;
  logic [CHANNELS-1:0] tgl_q, tgl_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Glitch filter: a differing d must persist FILTER enabled edges to update y
  always_comb begin
    y_d   = y_q;
    tgl_d = '0;
    cnt_d = cnt_q;
    if (en) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (d_c[c] == y_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CNT_MAX) begin
          y_d[c]   = d_c[c];
          cnt_d[c] = '0;
          tgl_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= RESET_VAL;
      tgl_q <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      y_q   <= y_d;
      tgl_q <= tgl_d;
      cnt_q <= cnt_d;
    end
  end

  assign y   = y_q;
  assign tgl = tgl_q;

endmodule

// File: tb/tb_ttl_gate_bank_sync.sv
// Bench for ttl_gate_bank_sync: directed scenarios plus random traffic against a
// history-queue / run-length reference model.
module tb_ttl_gate_bank_sync;

  localparam int unsigned CH  = 3;
  localparam int unsigned IN  = 3;
  localparam int unsigned LAT = 2;
  localparam int unsigned FLT = 3;
  localparam logic [CH-1:0] RV = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [1:0]        mode;
  logic [CH*IN-1:0]  a;
  logic [CH-1:0]     y;
  logic [CH-1:0]     tgl;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [CH-1:0] m_hist[$];
  int            m_run [CH];
  logic [CH-1:0] m_y;
  logic [CH-1:0] m_tgl;

  ttl_gate_bank_sync #(
    .CHANNELS (CH),
    .INPUTS   (IN),
    .LATENCY  (LAT),
    .FILTER   (FLT),
    .RESET_VAL(RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .a   (a),
    .y   (y),
    .tgl (tgl)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] ref_gate(input logic [1:0] m, input logic [CH*IN-1:0] av);
    logic [CH-1:0] r;
    int n;
    r = '0;
    for (int c = 0; c < int'(CH); c++) begin
      n = $countones(av[c*IN +: IN]);
      case (m)
        2'd0:    r[c] = (n == 0);
        2'd1:    r[c] = (n != 0);
        2'd2:    r[c] = (n != int'(IN));
        default: r[c] = (n == int'(IN));
      endcase
    end
    return r;
  endfunction

  // Model: d is the gate value seen LAT-1 enabled edges ago; y flips after FLT consecutive mismatches
  task automatic model_edge();
    logic [CH-1:0] gv, dv;
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < int'(LAT) - 1; i++) m_hist.push_back(RV);
      m_y   = RV;
      m_tgl = '0;
      for (int c = 0; c < int'(CH); c++) m_run[c] = 0;
    end else if (!en) begin
      m_tgl = '0;
    end else begin
      gv = ref_gate(mode, a);
      if (LAT == 1) begin
        dv = gv;
      end else begin
        dv = m_hist.pop_front();
        m_hist.push_back(gv);
      end
      m_tgl = '0;
      for (int c = 0; c < int'(CH); c++) begin
        if (dv[c] == m_y[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == int'(FLT)) begin
            m_y[c]   = dv[c];
            m_run[c] = 0;
            m_tgl[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    a = '0; mode = 2'b00; en = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a = '0; mode = 2'b00; en = 1'b1; rst = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_cmp++;
      if (y !== 3'b111 || tgl !== 3'b000 || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL reset edge%0d: y=%b tgl=%b, want y=111 tgl=000", k, y, tgl);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (y !== 3'b111 || tgl !== 3'b000 || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL post_reset edge%0d: y=%b tgl=%b, want y=111 tgl=000", k, y, tgl);
      end
    end
  endtask

  task automatic test_step();
    logic [CH-1:0] ey, et;
    a = 9'h001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ey = (k >= 4) ? 3'b110 : 3'b111;
      et = (k == 4) ? 3'b001 : 3'b000;
      n_cmp++;
      if (y !== ey || tgl !== et || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL step edge%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, ey, et);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    a = 9'h008;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) a = '0;
      n_cmp++;
      if (y !== 3'b111 || tgl !== 3'b000 || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL glitch edge%0d: y=%b tgl=%b, want y=111 tgl=000", k, y, tgl);
      end
    end
  endtask

  task automatic test_and_mode();
    logic [CH-1:0] ey, et;
    do_reset();
    mode = 2'b11; a = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ey = (k >= 4) ? 3'b000 : 3'b111;
      et = (k == 4) ? 3'b111 : 3'b000;
      n_cmp++;
      if (y !== ey || tgl !== et || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL and_low edge%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, ey, et);
      end
    end
    a = 9'h1FF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ey = (k >= 4) ? 3'b111 : 3'b000;
      et = (k == 4) ? 3'b111 : 3'b000;
      n_cmp++;
      if (y !== ey || tgl !== et || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL and_high edge%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, ey, et);
      end
    end
  endtask

  task automatic test_enable();
    logic [CH-1:0] ey, et;
    do_reset();
    a = 9'h001;
    tick(); tick();
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (y !== 3'b111 || tgl !== 3'b000 || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL en_hold edge%0d: y=%b tgl=%b, want y=111 tgl=000", k, y, tgl);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      ey = (k >= 2) ? 3'b110 : 3'b111;
      et = (k == 2) ? 3'b001 : 3'b000;
      n_cmp++;
      if (y !== ey || tgl !== et || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL en_resume edge%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, ey, et);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [CH-1:0] ey, et;
    do_reset();
    a = 9'h001;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (y !== 3'b111 || tgl !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset: y=%b tgl=%b, want y=111 tgl=000", y, tgl);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      ey = (k >= 4) ? 3'b110 : 3'b111;
      et = (k == 4) ? 3'b001 : 3'b000;
      n_cmp++;
      if (y !== ey || tgl !== et || y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL after_mid_reset edge%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, ey, et);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      // Hold inputs for short random runs so both glitches and real steps occur
      if ($urandom_range(0, 3) == 0) a = CH*IN'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      en  = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
      n_cmp++;
      if (y !== m_y || tgl !== m_tgl) begin
        n_bad++;
        $display("FAIL random cyc%0d: y=%b tgl=%b, want y=%b tgl=%b", k, y, tgl, m_y, m_tgl);
      end
    end
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; a = '0;
    m_y = RV; m_tgl = '0;
    for (int c = 0; c < int'(CH); c++) m_run[c] = 0;
    #2;
    test_reset();
    test_step();
    test_glitch();
    test_and_mode();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
